// File: rtl/tpg_pkg.sv
// Shared definitions for the test pattern generator: mode encodings
// and the colour bar palette, ordered left to right across the line.
package tpg_pkg;

   localparam logic [1:0] TPG_SOLID   = 2'd0;
   localparam logic [1:0] TPG_BARS    = 2'd1;
   localparam logic [1:0] TPG_CHECKER = 2'd2;
   localparam logic [1:0] TPG_RAMP    = 2'd3;

   localparam logic [23:0] TPG_BAR0 = 24'hFFFFFF;
   localparam logic [23:0] TPG_BAR1 = 24'hFFFF00;
   localparam logic [23:0] TPG_BAR2 = 24'h00FFFF;
   localparam logic [23:0] TPG_BAR3 = 24'h00FF00;
   localparam logic [23:0] TPG_BAR4 = 24'hFF00FF;
   localparam logic [23:0] TPG_BAR5 = 24'hFF0000;
   localparam logic [23:0] TPG_BAR6 = 24'h0000FF;
   localparam logic [23:0] TPG_BAR7 = 24'h000000;

   function automatic logic [23:0] tpg_bar_color(input logic [2:0] idx);
      logic [23:0] c;
      unique case (idx)
         3'd0: c = TPG_BAR0;
         3'd1: c = TPG_BAR1;
         3'd2: c = TPG_BAR2;
         3'd3: c = TPG_BAR3;
         3'd4: c = TPG_BAR4;
         3'd5: c = TPG_BAR5;
         3'd6: c = TPG_BAR6;
         3'd7: c = TPG_BAR7;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/tpg_raster_counter.sv
// Raster position tracker: X/Y counters, bar sub-counter/index, frame flags.
// Ports: clk_i, rst_i (sync, high), advance_i (one pixel consumed);
//   outputs describe the NEXT pixel position: x8_o (X mod 256),
//   chk_o (X[CheckerLog2]^Y[CheckerLog2]), bar_o, start_o (next is (0,0)),
//   wrap_o (this advance ends the frame).
module tpg_raster_counter
   import tpg_pkg::*;
#(
   parameter int Width       = 800,
   parameter int Height      = 600,
   parameter int CheckerLog2 = 5
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       advance_i,
   output logic [7:0] x8_o,
   output logic       chk_o,
   output logic [2:0] bar_o,
   output logic       start_o,
   output logic       wrap_o
);

   localparam int XW = $clog2(Width);
   localparam int YW = $clog2(Height);
   localparam int BW = $clog2(Width / 8);

   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic [BW-1:0] bcnt_q, bcnt_d;
   logic [2:0]    bidx_q, bidx_d;
   logic          x_last, y_last, b_last;
   logic          cx, cy;

   assign x_last = (x_q == XW'(Width - 1));
   assign y_last = (y_q == YW'(Height - 1));
   assign b_last = (bcnt_q == BW'(Width / 8 - 1));

   always_comb begin
      x_d    = x_q;
      y_d    = y_q;
      bcnt_d = bcnt_q;
      bidx_d = bidx_q;
      if (advance_i) begin
         if (x_last) begin
            x_d    = '0;
            bcnt_d = '0;
            bidx_d = '0;
            y_d    = y_last ? '0 : y_q + 1'b1;
         end else begin
            x_d = x_q + 1'b1;
            if (b_last) begin
               bcnt_d = '0;
               bidx_d = bidx_q + 3'd1;
            end else begin
               bcnt_d = bcnt_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         x_q    <= '0;
         y_q    <= '0;
         bcnt_q <= '0;
         bidx_q <= '0;
      end else begin
         x_q    <= x_d;
         y_q    <= y_d;
         bcnt_q <= bcnt_d;
         bidx_q <= bidx_d;
      end
   end

   // Bits beyond the counter width are constant zero.
   if (XW >= 8) begin : g_x8_wide
      assign x8_o = x_d[7:0];
   end else begin : g_x8_narrow
      assign x8_o = {{(8 - XW){1'b0}}, x_d};
   end

   if (CheckerLog2 < XW) begin : g_cx
      assign cx = x_d[CheckerLog2];
   end else begin : g_cx0
      assign cx = 1'b0;
   end

   if (CheckerLog2 < YW) begin : g_cy
      assign cy = y_d[CheckerLog2];
   end else begin : g_cy0
      assign cy = 1'b0;
   end

   assign chk_o   = cx ^ cy;
   assign bar_o   = bidx_d;
   assign start_o = (x_d == '0) && (y_d == '0);
   assign wrap_o  = advance_i && x_last && y_last;

endmodule

// File: rtl/test_pattern_gen.sv
// Test pattern source for the DVI Video/VideoValid/VideoReady port.
// Ports: Clock, Reset (sync, high), Mode[1:0] (taken at frame start),
//   Video[23:0] {R,G,B}, VideoValid, VideoReady, StartOfFrame.
// Build option TPG_SCROLL_EN: frame counter scrolls bars and ramp.
module test_pattern_gen
   import tpg_pkg::*;
#(
   parameter int          Width       = 800,
   parameter int          Height      = 600,
   parameter int          CheckerLog2 = 5,
   parameter logic [23:0] SolidColor  = 24'h0000FF
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [1:0]  Mode,
   output logic [23:0] Video,
   output logic        VideoValid,
   input  logic        VideoReady,
   output logic        StartOfFrame
);

   logic        valid_q;
   logic [23:0] video_q, video_d;
   logic        sof_q;
   logic [1:0]  mode_q, mode_eff;
   logic        load, advance;
   logic [7:0]  x8;
   logic        chk;
   logic [2:0]  bar;
   logic        start_nxt, wrap;
   logic [7:0]  ramp;
   logic [2:0]  bar_sel;

   assign advance = valid_q && VideoReady;
   // The very first load after reset fills the output with pixel (0,0).
   assign load    = !valid_q || VideoReady;

   tpg_raster_counter #(
      .Width       (Width),
      .Height      (Height),
      .CheckerLog2 (CheckerLog2)
   ) u_raster (
      .clk_i     (Clock),
      .rst_i     (Reset),
      .advance_i (advance),
      .x8_o      (x8),
      .chk_o     (chk),
      .bar_o     (bar),
      .start_o   (start_nxt),
      .wrap_o    (wrap)
   );

   // The pixel being loaded belongs to a new frame: use the live Mode.
   assign mode_eff = start_nxt ? Mode : mode_q;

`ifdef TPG_SCROLL_EN
   logic [7:0] f_q, f_d;

   assign f_d = wrap ? f_q + 8'd1 : f_q;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         f_q <= 8'd0;
      end else begin
         f_q <= f_d;
      end
   end

   assign ramp    = x8 + f_d;
   assign bar_sel = bar + f_d[7:5];
`else
   logic unused_wrap;

   assign unused_wrap = wrap;
   assign ramp        = x8;
   assign bar_sel     = bar;
`endif

   always_comb begin
      video_d = SolidColor;
      unique case (mode_eff)
         TPG_SOLID:   video_d = SolidColor;
         TPG_BARS:    video_d = tpg_bar_color(bar_sel);
         TPG_CHECKER: video_d = chk ? 24'h000000 : 24'hFFFFFF;
         TPG_RAMP:    video_d = {ramp, ramp, ramp};
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         valid_q <= 1'b0;
         video_q <= 24'h0;
         sof_q   <= 1'b0;
         mode_q  <= TPG_SOLID;
      end else if (load) begin
         valid_q <= 1'b1;
         video_q <= video_d;
         sof_q   <= start_nxt;
         if (start_nxt) begin
            mode_q <= Mode;
         end
      end
   end

   assign Video        = video_q;
   assign VideoValid   = valid_q;
   assign StartOfFrame = sof_q;

endmodule

// File: tb/tb_test_pattern_gen.sv
// Randomized bench for test_pattern_gen against a raster-level model.
module tb_test_pattern_gen;

   localparam int W  = 16;
   localparam int H  = 4;
   localparam int CL = 2;
`ifdef TPG_SCROLL_EN
   localparam int SCROLL = 1;
`else
   localparam int SCROLL = 0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ready = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic [23:0] video;
   logic        valid;
   logic        sof;

   int checks   = 0;
   int failures = 0;

   bit       m_valid = 1'b0;
   int       mx = 0;
   int       my = 0;
   int       mf = 0;
   int       mm = 0;

   logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF,
                             24'h00FF00, 24'hFF00FF, 24'hFF0000,
                             24'h0000FF, 24'h000000};

   always #5 clk = ~clk;

   test_pattern_gen #(
      .Width       (W),
      .Height      (H),
      .CheckerLog2 (CL),
      .SolidColor  (24'h0000FF)
   ) dut (
      .Clock        (clk),
      .Reset        (rst),
      .Mode         (mode),
      .Video        (video),
      .VideoValid   (valid),
      .VideoReady   (ready),
      .StartOfFrame (sof)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] exp_pix(int m, int x, int y, int f);
      int b;
      int v;
      case (m)
         0: return 24'h0000FF;
         1: begin
            b = (x / (W / 8) + SCROLL * (f / 32)) % 8;
            return bars[b];
         end
         2: return ((((x >> CL) ^ (y >> CL)) & 1) != 0)
                   ? 24'h000000 : 24'hFFFFFF;
         default: begin
            v = (x + SCROLL * f) % 256;
            return {v[7:0], v[7:0], v[7:0]};
         end
      endcase
   endfunction

   task automatic check_outputs();
      if (!m_valid) begin
         chk("valid_idle", 32'(valid), 32'd0);
         chk("video_idle", 32'(video), 32'd0);
         chk("sof_idle", 32'(sof), 32'd0);
      end else begin
         chk("valid", 32'(valid), 32'd1);
         chk("video", 32'(video), 32'(exp_pix(mm, mx, my, mf)));
         chk("sof", 32'(sof), 32'((mx == 0) && (my == 0)));
      end
   endtask

   task automatic model_edge();
      if (rst) begin
         m_valid = 1'b0;
         mx = 0;
         my = 0;
         mf = 0;
      end else if (!m_valid) begin
         m_valid = 1'b1;
         mm = int'(mode);
      end else if (ready) begin
         mx++;
         if (mx == W) begin
            mx = 0;
            my++;
            if (my == H) begin
               my = 0;
               mf = (mf + 1) % 256;
               mm = int'(mode);
            end
         end
      end
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic cycle(input bit rdy);
      check_outputs();
      ready = rdy;
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic run(input int n, input bit rnd);
      for (int i = 0; i < n; i++) begin
         cycle(rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      end
   endtask

   initial begin
      int cnt;
      bit hit;

      // 1: reset, then first pixel.
      rst  = 1'b1;
      mode = 2'd0;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      run(3, 1'b1);
      rst = 1'b0;
      cycle(1'b0);
      chk("t1_valid", 32'(valid), 32'd1);
      chk("t1_video", 32'(video), 32'h0000FF);
      chk("t1_sof", 32'(sof), 32'd1);

      // 2: bars, full-rate; frame period is W*H transfers.
      mode = 2'd1;
      cnt  = 0;
      while (!sof && cnt < 200) begin
         cycle(1'b1);
         cnt++;
      end
      cnt = 0;
      do begin
         cycle(1'b1);
         cnt++;
      end while (!sof && cnt < 200);
      chk("t2_sof_period", 32'(cnt), 32'(W * H));
      run(2 * W * H, 1'b0);

      // 3: checker, random ready.
      mode = 2'd2;
      run(6 * W * H, 1'b1);

      // 4: solid frame, switch to ramp after 10 transfers.
      mode = 2'd0;
      cnt  = 0;
      while (!(m_valid && mx == 0 && my == 0) && cnt < 1000) begin
         run(1, 1'b1);
         cnt++;
      end
      chk("t4_frame_start", 32'(m_valid && mx == 0 && my == 0), 32'd1);
      cnt = 0;
      while (cnt < 10) begin
         cycle(1'b1);
         cnt++;
      end
      mode = 2'd3;
      run(6 * W * H, 1'b1);

      // Random mode changes every cycle; only frame starts take effect.
      for (int i = 0; i < 8 * W * H; i++) begin
         mode = 2'($urandom_range(0, 3));
         run(1, 1'b1);
      end

      // 5: reset pulse at pixel (5,2).
      mode = 2'd1;
      hit  = 1'b0;
      for (int i = 0; i < 2000 && !hit; i++) begin
         if (m_valid && mx == 5 && my == 2) begin
            hit = 1'b1;
         end else begin
            run(1, 1'b1);
         end
      end
      chk("t5_reached", 32'(hit), 32'd1);
      rst = 1'b1;
      cycle(1'b1);
      rst = 1'b0;
      cycle(1'b1);
      chk("t5_restart_sof", 32'(sof), 32'd1);
      chk("t5_restart_px", 32'(video), 32'hFFFFFF);
      run(3 * W * H, 1'b1);

`ifdef TPG_SCROLL_EN
      // 6: scrolling ramp across the 8-bit frame counter wrap.
      mode = 2'd3;
      rst  = 1'b1;
      cycle(1'b1);
      rst  = 1'b0;
      run(257 * W * H + 4, 1'b0);
      mode = 2'd1;
      run(40 * W * H, 1'b0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
